fan_timer_fnd_driver: RTL and testbench

//  Consumer of the fan timer's display interface. Takes the packed BCD mm:ss

---
 rtl/fan_timer_fnd_driver.sv | 107 ++++++++++
 tb/tb_fan_timer_fnd_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fan_timer_fnd_driver.sv
// fan_timer_fnd_driver: multiplexed 4-digit 7-segment driver for the fan timer mm:ss display
module fan_timer_fnd_driver #(
  parameter int SCAN_DIV     = 100_000,
  parameter int HALF_DIV     = 50_000_000,
  parameter int BLINK_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        state,
  input  logic        timeout,
  input  logic [15:0] value_timer,
  output logic [3:0]  com,
  output logic [7:0]  seg_7,
  output logic [1:0]  disp_mode
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int HW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, BLINK, DONE} mode_t;
  mode_t mode, mode_n;
  logic [15:0]   value_q;
  logic          timeout_q, state_q, timeout_d;
  logic [SW-1:0] scan_cnt, scan_n;
  logic [1:0]    idx, idx_n;
  logic [HW-1:0] half_cnt, half_n;
  logic          phase, phase_n;
  logic [BW-1:0] blink_cnt, blink_n;
  logic [3:0]    com_n, nib;
  logic [7:0]    seg_n;
  logic          scan_wrap, half_wrap, fall, entry, blink_end, show;
  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 8'h03;
      4'd1: decode = 8'h9F;
      4'd2: decode = 8'h25;
      4'd3: decode = 8'h0D;
      4'd4: decode = 8'h99;
      4'd5: decode = 8'h49;
      4'd6: decode = 8'h41;
      4'd7: decode = 8'h1F;
      4'd8: decode = 8'h01;
      4'd9: decode = 8'h09;
      default: decode = 8'hFD;
    endcase
  endfunction
  always_comb begin
    scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
    half_wrap = half_cnt == HW'(HALF_DIV - 1);
    fall      = timeout_d & ~timeout_q;
    blink_end = half_wrap & phase & (blink_cnt == BW'(BLINK_CYCLES - 1));
    mode_n    = mode;
    if (!state_q) mode_n = IDLE;
    else
      case (mode)
        IDLE:  mode_n = RUN;
        RUN:   if (fall) mode_n = BLINK;
        BLINK: if (timeout_q) mode_n = RUN; else if (blink_end) mode_n = DONE;
        DONE:  if (timeout_q) mode_n = RUN;
        default: mode_n = IDLE;
      endcase
    entry   = mode_n != mode && (mode_n == RUN || mode_n == BLINK);
    scan_n  = scan_wrap ? '0 : scan_cnt + 1'b1;
    idx_n   = idx + {1'b0, scan_wrap};
    half_n  = (entry || half_wrap) ? '0 : half_cnt + 1'b1;
    phase_n = entry ? 1'b0 : phase ^ half_wrap;
    blink_n = (mode == BLINK && mode_n == BLINK) ? blink_cnt + BW'(half_wrap & phase) : '0;
    nib     = value_q[{idx_n, 2'b00} +: 4];
    // a zero tens-of-minutes digit is blanked, except in continuous mode (value 0) which shows dashes
    show    = (mode_n == RUN && !(value_q != 16'h0 && idx_n == 2'd3 && nib == 4'h0)) ||
              (mode_n == BLINK && !phase_n);
    com_n   = show ? ~(4'b0001 << idx_n) : 4'b1111;
    seg_n   = !show ? 8'hFF :
              mode_n == BLINK ? 8'h03 :
              value_q == 16'h0 ? 8'hFD :
              decode(nib) & {7'h7F, !(idx_n == 2'd2 && !phase_n)};
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      value_q   <= '0;
      timeout_q <= 1'b0;
      state_q   <= 1'b0;
      timeout_d <= 1'b0;
      mode      <= IDLE;
      scan_cnt  <= '0;
      idx       <= '0;
      half_cnt  <= '0;
      phase     <= 1'b0;
      blink_cnt <= '0;
      com       <= 4'b1111;
      seg_7     <= 8'hFF;
    end else begin
      value_q   <= value_timer;
      timeout_q <= timeout;
      state_q   <= state;
      timeout_d <= mode == IDLE ? 1'b0 : timeout_q;
      mode      <= mode_n;
      scan_cnt  <= scan_n;
      idx       <= idx_n;
      half_cnt  <= half_n;
      phase     <= phase_n;
      blink_cnt <= blink_n;
      com       <= com_n;
      seg_7     <= seg_n;
    end
  end
  assign disp_mode = mode;
endmodule

// File: tb/tb_fan_timer_fnd_driver.sv
// tb_fan_timer_fnd_driver: randomized and directed checks of the display driver against a timeline model
module tb_fan_timer_fnd_driver;
  localparam int S = 4, H = 32, B = 2;
  logic clk = 1'b0, reset_p = 1'b1, state = 1'b0, timeout = 1'b0;
  logic [15:0] value_timer = '0;
  logic [3:0] com;
  logic [7:0] seg_7;
  logic [1:0] disp_mode;
  int checks = 0, errors = 0;
  int n, e;
  logic [1:0] m_mode;
  logic m_sq, m_tq, m_tprev;
  logic [15:0] m_vq;
  logic [3:0] exp_com;
  logic [7:0] exp_seg;

  fan_timer_fnd_driver #(.SCAN_DIV(S), .HALF_DIV(H), .BLINK_CYCLES(B)) dut (
    .clk(clk), .reset_p(reset_p), .state(state), .timeout(timeout),
    .value_timer(value_timer), .com(com), .seg_7(seg_7), .disp_mode(disp_mode));

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'b0000_0011; 1: return 8'b1001_1111; 2: return 8'b0010_0101;
      3: return 8'b0000_1101; 4: return 8'b1001_1001; 5: return 8'b0100_1001;
      6: return 8'b0100_0001; 7: return 8'b0001_1111; 8: return 8'b0000_0001;
      9: return 8'b0000_1001; default: return 8'b1111_1101;
    endcase
  endfunction

  // Model: digit slot and blink phase follow from elapsed clock counts since reset / mode entry.
  task automatic step();
    logic [1:0] old_mode, nm;
    int idx, ph, d;
    logic [3:0] oh;
    if (reset_p) begin
      n = 0; e = 0; m_mode = 2'd0; m_sq = 0; m_tq = 0; m_tprev = 0; m_vq = '0;
      exp_com = 4'hF; exp_seg = 8'hFF;
    end else begin
      n++;
      old_mode = m_mode;
      nm = old_mode;
      if (!m_sq) nm = 2'd0;
      else if (old_mode == 2'd0) nm = 2'd1;
      else if (old_mode == 2'd1) nm = (m_tprev && !m_tq) ? 2'd2 : 2'd1;
      else if (m_tq) nm = 2'd1;
      else if (old_mode == 2'd2 && n - e == 2 * H * B) nm = 2'd3;
      if (nm != old_mode && (nm == 2'd1 || nm == 2'd2)) e = n;
      m_mode = nm;
      idx = (n / S) % 4;
      ph = ((n - e) / H) % 2;
      d = int'((m_vq >> (4 * idx)) & 16'hF);
      oh = 4'b0001 << idx;
      exp_com = 4'hF; exp_seg = 8'hFF;
      if (nm == 2'd1) begin
        if (m_vq == 16'h0) begin exp_com = ~oh; exp_seg = 8'hFD; end
        else if (!(idx == 3 && d == 0)) begin
          exp_com = ~oh; exp_seg = glyph(d);
          if (idx == 2 && ph == 0) exp_seg[0] = 1'b0;
        end
      end else if (nm == 2'd2 && ph == 0) begin
        exp_com = ~oh; exp_seg = glyph(0);
      end
      m_tprev = (old_mode == 2'd0) ? 1'b0 : m_tq;
      m_sq = state; m_tq = timeout; m_vq = value_timer;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_p = 1; state = 1; timeout = 1; value_timer = 16'h0125;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (com !== 4'b1111 || seg_7 !== 8'hFF || disp_mode !== 2'd0) begin
        errors++;
        $display("FAIL reset cyc %0d com %b want 1111 seg %h want ff mode %0d want 0", i, com, seg_7, disp_mode);
      end
    end
  endtask

  task automatic run_cmp(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      checks++;
      if (com !== exp_com || seg_7 !== exp_seg || disp_mode !== m_mode) begin
        errors++;
        $display("FAIL %s n %0d com %b want %b seg %h want %h mode %0d want %0d",
                 name, n, com, exp_com, seg_7, exp_seg, disp_mode, m_mode);
      end
    end
  endtask

  task automatic test_run_digits();
    reset_p = 0; state = 1; timeout = 1; value_timer = 16'h0125;
    run_cmp("run_digits", 80);
  endtask

  task automatic test_continuous();
    value_timer = 16'h0000;
    run_cmp("continuous", 40);
  endtask

  task automatic test_dash_decode();
    value_timer = 16'h00A3;
    run_cmp("dash_decode", 40);
  endtask

  task automatic test_blink_done();
    value_timer = 16'h0125;
    run_cmp("blink_pre", 6);
    timeout = 0;
    run_cmp("blink", 140);
    checks++;
    if (disp_mode !== 2'd3) begin
      errors++;
      $display("FAIL blink_done mode %0d want 3", disp_mode);
    end
    timeout = 1;
    run_cmp("blink_reload", 2);
    checks++;
    if (disp_mode !== 2'd1) begin
      errors++;
      $display("FAIL reload_run mode %0d want 1", disp_mode);
    end
  endtask

  task automatic test_state_drop();
    run_cmp("drop_pre", 6);
    timeout = 0;
    run_cmp("drop_blink", 10);
    state = 0;
    run_cmp("drop", 2);
    checks++;
    if (com !== 4'b1111 || disp_mode !== 2'd0) begin
      errors++;
      $display("FAIL state_drop com %b want 1111 mode %0d want 0", com, disp_mode);
    end
    state = 1;
    run_cmp("drop_resume", 12);
    checks++;
    if (disp_mode !== 2'd1) begin
      errors++;
      $display("FAIL stale_edge mode %0d want 1", disp_mode);
    end
    timeout = 1;
    run_cmp("drop_post", 4);
  endtask

  task automatic test_reset_mid_run();
    run_cmp("mid_pre", 7);
    reset_p = 1;
    step();
    checks++;
    if (com !== 4'b1111 || seg_7 !== 8'hFF || disp_mode !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid com %b want 1111 seg %h want ff mode %0d want 0", com, seg_7, disp_mode);
    end
    reset_p = 0;
    run_cmp("mid_post", 10);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset_p = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 49) == 0) state = ~state;
      if ($urandom_range(0, 59) == 0) timeout = ~timeout;
      if ($urandom_range(0, 19) == 0)
        case ($urandom_range(0, 3))
          0: value_timer = 16'h0000;
          1: value_timer = {8'h0, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
          2: value_timer = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
          default: value_timer = 16'($urandom);
        endcase
      run_cmp("random", 1);
    end
  endtask

  initial begin
    test_reset();
    test_run_digits();
    test_continuous();
    test_dash_decode();
    test_blink_done();
    test_state_drop();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
